// File: rtl/fc_feeder.sv
// fc_feeder: buffers one feature map and one binary weight vector,
// shifts the weights serially into fc, then issues gapped input beats.
module fc_feeder #(
  parameter int DW     = 32,
  parameter int LANES  = 6,
  parameter int NWORDS = 192,
  parameter int WBITS  = 192,
  parameter int GAP    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fm_valid,
  input  logic signed [DW-1:0] fm_data,
  output logic                 fm_ready,
  input  logic                 w_valid,
  input  logic [31:0]          w_word,
  output logic                 w_ready,
  output logic                 weight_en,
  output logic                 weight,
  output logic                 ivalid,
  output logic signed [DW-1:0] din_0,
  output logic signed [DW-1:0] din_1,
  output logic signed [DW-1:0] din_2,
  output logic signed [DW-1:0] din_3,
  output logic signed [DW-1:0] din_4,
  output logic signed [DW-1:0] din_5,
  output logic                 busy,
  output logic                 done
);

  localparam int NB  = NWORDS / LANES;
  localparam int NW  = WBITS / 32;
  localparam int CW  = $clog2(NWORDS + 1);
  localparam int IW  = $clog2(NWORDS);
  localparam int WCW = $clog2(NW + 1);
  localparam int WIW = $clog2(NW);
  localparam int KW  = $clog2(WBITS);
  localparam int BW  = $clog2(NB);
  localparam int PW  = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    LOAD, WSTREAM, FEED, DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]  fm_cnt, fm_cnt_n;
  logic [WCW-1:0] w_cnt, w_cnt_n;
  logic           fm_rdy_q, w_rdy_q;
  logic           fm_acc, w_acc;
  logic [KW-1:0]  k;
  logic [BW-1:0]  b, ld_b;
  logic [PW-1:0]  p;
  logic           ld_beat;

  logic signed [DW-1:0] fm_mem [NWORDS];
  logic [31:0]          wreg [NW];
  logic signed [DW-1:0] din_q [LANES];

  // ready is registered; masking with rst keeps it low in the rst cycle
  assign fm_ready = fm_rdy_q & ~rst;
  assign w_ready  = w_rdy_q & ~rst;
  assign fm_acc   = fm_valid & fm_ready;
  assign w_acc    = w_valid & w_ready;

  always_comb begin
    state_n  = state;
    fm_cnt_n = fm_cnt;
    w_cnt_n  = w_cnt;
    ld_beat  = 1'b0;
    ld_b     = '0;
    if (fm_acc) fm_cnt_n = fm_cnt + 1'b1;
    if (w_acc)  w_cnt_n  = w_cnt + 1'b1;
    unique case (1'b1)
      (state == LOAD): begin
        if (fm_cnt_n == CW'(NWORDS) &&
            w_cnt_n == WCW'(NW))
          state_n = WSTREAM;
      end
      (state == WSTREAM): begin
        if (k == KW'(WBITS - 1)) begin
          state_n = FEED;
          ld_beat = 1'b1;
        end
      end
      (state == FEED): begin
        if (p == PW'(GAP)) begin
          if (b == BW'(NB - 1)) begin
            state_n = DONE;
          end else begin
            ld_beat = 1'b1;
            ld_b    = b + 1'b1;
          end
        end
      end
      (state == DONE): begin
        state_n  = LOAD;
        fm_cnt_n = '0;
        w_cnt_n  = '0;
      end
      default: state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      fm_cnt   <= '0;
      w_cnt    <= '0;
      fm_rdy_q <= 1'b1;
      w_rdy_q  <= 1'b1;
      k        <= '0;
      b        <= '0;
      p        <= '0;
    end else begin
      state    <= state_n;
      fm_cnt   <= fm_cnt_n;
      w_cnt    <= w_cnt_n;
      fm_rdy_q <= (state_n == LOAD) &&
                  (fm_cnt_n != CW'(NWORDS));
      w_rdy_q  <= (state_n == LOAD) &&
                  (w_cnt_n != WCW'(NW));
      k        <= (state == WSTREAM) ? k + 1'b1 : '0;
      if (state == FEED) begin
        if (p == PW'(GAP)) begin
          p <= '0;
          b <= b + 1'b1;
        end else begin
          p <= p + 1'b1;
        end
      end else begin
        p <= '0;
        b <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fm_acc) fm_mem[fm_cnt[IW-1:0]] <= fm_data;
    if (w_acc)  wreg[w_cnt[WIW-1:0]]   <= w_word;
  end

  // lanes load on entry to each beat cycle and hold through the gap
  always_ff @(posedge clk) begin
    if (rst || state == DONE) begin
      for (int j = 0; j < LANES; j++) din_q[j] <= '0;
    end else if (ld_beat) begin
      for (int j = 0; j < LANES; j++)
        din_q[j] <= fm_mem[IW'(ld_b) * IW'(LANES) + IW'(j)];
    end
  end

  assign weight_en = (state == WSTREAM);
  assign weight    = (state == WSTREAM) & ~wreg[k[KW-1:5]][k[4:0]];
  assign ivalid    = (state == FEED) && (p == '0);
  assign busy      = (state == WSTREAM) || (state == FEED);
  assign done      = (state == DONE);

  assign din_0 = din_q[0];
  assign din_1 = din_q[1];
  assign din_2 = din_q[2];
  assign din_3 = din_q[3];
  assign din_4 = din_q[4];
  assign din_5 = din_q[5];

endmodule

// File: tb/tb_fc_feeder.sv
// tb_fc_feeder: directed bench for fc_feeder with
// immediate-assertion checks and hand-derived expectations.
module tb_fc_feeder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               fm_valid = 1'b0;
  logic signed [31:0] fm_data = '0;
  logic               fm_ready;
  logic               w_valid = 1'b0;
  logic [31:0]        w_word = '0;
  logic               w_ready;
  logic               weight_en, weight, ivalid, busy, done;
  logic signed [31:0] din_0, din_1, din_2, din_3, din_4, din_5;

  always #5 clk = ~clk;

  fc_feeder dut (
    .clk(clk), .rst(rst),
    .fm_valid(fm_valid), .fm_data(fm_data), .fm_ready(fm_ready),
    .w_valid(w_valid), .w_word(w_word), .w_ready(w_ready),
    .weight_en(weight_en), .weight(weight), .ivalid(ivalid),
    .din_0(din_0), .din_1(din_1), .din_2(din_2),
    .din_3(din_3), .din_4(din_4), .din_5(din_5),
    .busy(busy), .done(done)
  );

  int ntests = 0;
  int nfail  = 0;

  logic signed [31:0] fv [192];
  logic [31:0]        wv [6];
  logic               wbit [192];
  int                 npulse, nadj, last_f, last_w;
  logic signed [31:0] b0_first, b31_last;

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int f_start, input int f_div,
                      input int w_start, input bit extra);
    int fi, wi, c;
    bit af, aw;
    fi = 0; wi = 0; c = 0;
    while ((fi < 192 || wi < 6) && c < 3000) begin
      if (fi < 192) begin
        fm_valid = (c >= f_start) && (((c - f_start) % f_div) == 0);
        fm_data  = fv[fi];
      end else begin
        fm_valid = extra;
        fm_data  = 32'h7777_7777;
      end
      w_valid = (wi < 6) && (c >= w_start);
      w_word  = (wi < 6) ? wv[wi] : 32'h0;
      af = fm_valid && fm_ready;
      aw = w_valid && w_ready;
      step();
      if (af) begin fi++; last_f = c; end
      if (aw) begin wi++; last_w = c; end
      c++;
    end
    fm_valid = extra;
    fm_data  = 32'h7777_7777;
    w_valid  = 1'b0;
    check("load_bound", c < 3000, 1);
    check("fill_to_wen", weight_en, 1);
    check("fm_ready_full", fm_ready, 0);
    check("w_ready_full", w_ready, 0);
  endtask

  task automatic run(input string tag);
    int serr, ferr, cnt, bb;
    logic prev;
    serr = 0; cnt = 1;
    for (int k = 0; k < 192; k++) begin
      wbit[k] = weight;
      if (!(weight_en === 1'b1 && weight === ~wv[k/32][k%32] &&
            busy === 1'b1 && ivalid === 1'b0 &&
            fm_ready === 1'b0 && w_ready === 1'b0))
        serr++;
      step(); cnt++;
    end
    check($sformatf("%s_stream", tag), serr, 0);
    ferr = 0; npulse = 0; nadj = 0; prev = 1'b0;
    for (int c = 0; c < 64; c++) begin
      bb = c / 2;
      if (ivalid === 1'b1) npulse++;
      if (prev === 1'b1 && ivalid === 1'b1) nadj++;
      prev = ivalid;
      if (ivalid !== ((c % 2) == 0)) ferr++;
      if (weight_en !== 1'b0 || weight !== 1'b0 || busy !== 1'b1 ||
          done !== 1'b0 || fm_ready !== 1'b0) ferr++;
      if (din_0 !== fv[6*bb]   || din_1 !== fv[6*bb+1] ||
          din_2 !== fv[6*bb+2] || din_3 !== fv[6*bb+3] ||
          din_4 !== fv[6*bb+4] || din_5 !== fv[6*bb+5]) ferr++;
      if (c == 0)  b0_first = din_0;
      if (c == 63) b31_last = din_5;
      step(); cnt++;
    end
    check($sformatf("%s_feed", tag), ferr, 0);
    check($sformatf("%s_pulses", tag), npulse, 32);
    check($sformatf("%s_adjacent", tag), nadj, 0);
    for (int i = 0; i < 8 && done !== 1'b1; i++) begin
      step(); cnt++;
    end
    check($sformatf("%s_done", tag), done, 1);
    check($sformatf("%s_done_at", tag), cnt, 257);
    check($sformatf("%s_busy_done", tag), busy, 0);
    check($sformatf("%s_iv_done", tag), ivalid, 0);
    step();
    check($sformatf("%s_done_pulse", tag), done, 0);
    check($sformatf("%s_fm_rdy_back", tag), fm_ready, 1);
    check($sformatf("%s_w_rdy_back", tag), w_ready, 1);
    check($sformatf("%s_din_clr", tag), din_0, 0);
  endtask

  initial begin
    int nd, nw;
    // reset
    step(); step();
    check("rst_fm_ready", fm_ready, 0);
    check("rst_w_ready", w_ready, 0);
    rst = 1'b0;
    #1;
    check("post_fm_ready", fm_ready, 1);
    check("post_w_ready", w_ready, 1);
    check("post_wen", weight_en, 0);
    check("post_weight", weight, 0);
    check("post_ivalid", ivalid, 0);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_din", din_3, 0);

    // 1: ramp features, zero weights, concurrent fill
    for (int i = 0; i < 192; i++) fv[i] = i - 96;
    for (int i = 0; i < 6; i++) wv[i] = 32'h0;
    load(0, 1, 0, 1'b0);
    run("s1");
    check("s1_b0", b0_first, -96);
    check("s1_b31", b31_last, 95);
    check("s1_w0", wbit[0], 1);
    check("s1_w191", wbit[191], 1);

    // 2: features first, extra valids while full, weights late
    for (int i = 0; i < 192; i++)
      fv[i] = (i % 2) ? -(i * 7) : (i * 7 + 1000);
    wv[0] = 32'h0000_0001;
    for (int i = 1; i < 6; i++) wv[i] = 32'hFFFF_FFFF;
    load(0, 1, 200, 1'b1);
    fm_valid = 1'b0;
    run("s2");
    check("s2_w0", wbit[0], 0);
    check("s2_w1", wbit[1], 1);
    check("s2_w31", wbit[31], 1);
    check("s2_w32", wbit[32], 0);
    check("s2_w191", wbit[191], 0);

    // 3: weights first, gapped features, valids held during run
    for (int i = 0; i < 192; i++) fv[i] = -(i * 65537) - 1;
    wv[0] = 32'hA5A5_0F0F; wv[1] = 32'h1234_5678;
    wv[2] = 32'h8000_0001; wv[3] = 32'hDEAD_BEEF;
    wv[4] = 32'h0F0F_F0F0; wv[5] = 32'h7FFF_FFFE;
    load(50, 3, 0, 1'b1);
    check("s3_order", last_f > last_w, 1);
    run("s3");
    fm_valid = 1'b0;

    // 5: reset in the middle of FEED
    for (int i = 0; i < 192; i++) fv[i] = i - 96;
    for (int i = 0; i < 6; i++) wv[i] = 32'h0;
    load(0, 1, 0, 1'b0);
    for (int i = 0; i < 192 + 20; i++) step();
    check("s5_beat10_iv", ivalid, 1);
    check("s5_beat10_din", din_0, -36);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("s5_rst_iv", ivalid, 0);
    check("s5_rst_wen", weight_en, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_fm_rdy", fm_ready, 1);
    nd = 0; nw = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) nd++;
      if (weight_en === 1'b1) nw++;
      step();
    end
    check("s5_no_done", nd, 0);
    check("s5_no_wen", nw, 0);
    load(0, 1, 0, 1'b0);
    run("s5r");
    check("s5r_b0", b0_first, -96);
    check("s5r_b31", b31_last, 95);

    // 6: last feature and last weight accepted together
    for (int i = 0; i < 192; i++) fv[i] = 3 * i - 200;
    wv[0] = 32'hFFFF_0000; wv[1] = 32'h0000_FFFF;
    wv[2] = 32'hAAAA_AAAA; wv[3] = 32'h5555_5555;
    wv[4] = 32'h0000_0000; wv[5] = 32'hFFFF_FFFF;
    load(0, 1, 186, 1'b0);
    check("s6_last_f", last_f, 191);
    check("s6_last_w", last_w, 191);
    run("s6");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
